// File: rtl/halut_result_fifo_if.sv
// Result FIFO bus: decoder-array capture side and writeback handshake side.
// slave = FIFO, master = producer/consumer environment.
interface halut_result_fifo_if #(
  parameter int unsigned DecAddrWidth = 2,
  parameter int unsigned CntWidth     = 4
);
  logic [31:0]             result_i;
  logic                    valid_i;
  logic [DecAddrWidth-1:0] m_addr_i;
  logic [31:0]             result_o;
  logic [DecAddrWidth-1:0] m_addr_o;
  logic                    valid_o;
  logic                    ready_i;
  logic [CntWidth-1:0]     count_o;
  logic                    full_o;
  logic                    empty_o;
  logic                    row_done_o;
  logic                    flush_i;
  logic                    clear_err_i;
  logic                    overflow_o;
  logic                    seq_err_o;

  modport slave (
    input  result_i, valid_i, m_addr_i,
    input  ready_i, flush_i, clear_err_i,
    output result_o, m_addr_o, valid_o,
    output count_o, full_o, empty_o,
    output row_done_o, overflow_o, seq_err_o
  );

  modport master (
    output result_i, valid_i, m_addr_i,
    output ready_i, flush_i, clear_err_i,
    input  result_o, m_addr_o, valid_o,
    input  count_o, full_o, empty_o,
    input  row_done_o, overflow_o, seq_err_o
  );
endinterface

// File: rtl/halut_result_fifo.sv
// Output FIFO behind the decoder array: absorbs bursts, flags drops
// and non-contiguous row indices, hands results to writeback.
package halut_pkg;
  localparam int unsigned DecoderUnits = 4;
endpackage

module halut_result_fifo #(
  parameter int unsigned DecoderUnits = halut_pkg::DecoderUnits,
  parameter int unsigned Depth        = 8,
  parameter int unsigned DecAddrWidth = $clog2(DecoderUnits),
  parameter int unsigned PtrWidth     = $clog2(Depth),
  parameter int unsigned CntWidth     = $clog2(Depth + 1)
) (
  input logic              clk_i,
  input logic              rst_i,
  halut_result_fifo_if.slave bus
);
  localparam logic [DecAddrWidth-1:0] LastRow =
    DecAddrWidth'(DecoderUnits - 1);

  logic [31:0]             mem_res  [Depth];
  logic [DecAddrWidth-1:0] mem_addr [Depth];

  logic [PtrWidth-1:0]     rd_ptr;
  logic [PtrWidth-1:0]     wr_ptr;
  logic [CntWidth-1:0]     cnt;
  logic [DecAddrWidth-1:0] exp_q;
  logic [DecAddrWidth-1:0] exp_nxt;
  logic                    ovf_q;
  logic                    seq_q;
  logic                    done_q;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;
  logic flush;
  logic clr;
  logic seq_bad;

  assign full    = cnt == CntWidth'(Depth);
  assign empty   = cnt == '0;
  assign flush   = bus.flush_i;
  assign clr     = bus.clear_err_i;
  assign pop     = !empty & bus.ready_i;
  assign push    = bus.valid_i & (!full | pop);
  assign drop    = bus.valid_i & full & !pop;
  assign seq_bad = bus.m_addr_i != exp_q;
  assign exp_nxt = (bus.m_addr_i == LastRow) ? '0
                 : bus.m_addr_i + DecAddrWidth'(1);

  // Flush wins over push/pop but never touches the sticky flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      exp_q  <= '0;
      ovf_q  <= 1'b0;
      seq_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= pop & !flush
              & (mem_addr[rd_ptr] == LastRow);
      ovf_q  <= (ovf_q & !clr) | (drop & !flush);
      seq_q  <= (seq_q & !clr)
              | (push & !flush & seq_bad);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        exp_q  <= '0;
      end else begin
        exp_q <= bus.valid_i ? exp_nxt : '0;
        if (push) begin
          mem_res[wr_ptr]  <= bus.result_i;
          mem_addr[wr_ptr] <= bus.m_addr_i;
          wr_ptr <= wr_ptr + PtrWidth'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PtrWidth'(1);
        if (push & !pop)
          cnt <= cnt + CntWidth'(1);
        else if (pop & !push)
          cnt <= cnt - CntWidth'(1);
      end
    end
  end

  assign bus.result_o   = empty ? '0 : mem_res[rd_ptr];
  assign bus.m_addr_o   = empty ? '0 : mem_addr[rd_ptr];
  assign bus.valid_o    = !empty;
  assign bus.count_o    = cnt;
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.row_done_o = done_q;
  assign bus.overflow_o = ovf_q;
  assign bus.seq_err_o  = seq_q;
endmodule

// File: doc/halut_result_fifo.md
Name: halut_result_fifo

Overview:
- Output buffer directly downstream of the multi-unit decoder array.
- Captures each FP32 result and its row index (m_addr) as the array serialises them, then offers them to the writeback/DMA side through a valid/ready handshake.
- The decoder array has no backpressure, so the block absorbs bursts, drops on overflow with a sticky flag, and checks that row indices arrive contiguously from 0.

Parameters:
- DecoderUnits, halut_pkg::DecoderUnits: rows per burst; upper bound of m_addr.
- Depth, 8: entries; power of two, >=2.
- DecAddrWidth, $clog2(DecoderUnits): row index width.
- PtrWidth, $clog2(Depth): read/write pointer width.
- CntWidth, $clog2(Depth+1): occupancy counter width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- result_i  in  32  FP32 result from the decoder array.
- valid_i  in  1  result_i/m_addr_i valid this cycle; no ready returned upstream.
- m_addr_i  in  DecAddrWidth  row index of result_i.
- result_o  out  32  head entry result.
- m_addr_o  out  DecAddrWidth  head entry row index.
- valid_o  out  1  head entry valid (FIFO not empty).
- ready_i  in  1  consumer accepts the head entry.
- count_o  out  CntWidth  occupancy.
- full_o  out  1  count_o == Depth.
- empty_o  out  1  count_o == 0.
- row_done_o  out  1  one-cycle pulse when the entry with m_addr == DecoderUnits-1 is popped.
- flush_i  in  1  synchronous discard of all contents.
- clear_err_i  in  1  clears sticky error flags.
- overflow_o  out  1  sticky: a result was dropped.
- seq_err_o  out  1  sticky: a non-contiguous m_addr was accepted.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - Pointers, count, expected index, overflow_o, seq_err_o and row_done_o go to 0.
  - valid_o=0, empty_o=1, full_o=0.
  - result_o and m_addr_o read 0 while empty; they are driven by a registered head copy or masked.
  - Reset mid-burst discards everything; the first post-reset push must carry m_addr 0, otherwise seq_err_o sets.
- Storage: register array of Depth x (32+DecAddrWidth).
- Pop:
  - pop = valid_o & ready_i.
  - Head is presented combinationally from the array at rd_ptr; no extra read latency.
- Push:
  - push = valid_i & (!full_o | pop).
  - Full-with-simultaneous-pop accepts the push.
- Latency: an entry pushed at edge N is visible on valid_o/result_o after edge N; earliest pop is at edge N+1.
- Pointers: wrap modulo Depth. count_o updates +1 on push only, -1 on pop only, and holds on both or neither.
- Overflow: valid_i & full_o & !pop drops the input, sets overflow_o, and leaves FIFO state unchanged.
- Sequence check on an expected-index register exp:
  - valid_i=0: exp <= 0 (matches the decoder array restarting its scan at row 0).
  - Accepted push with m_addr_i != exp: seq_err_o sets.
  - Accepted push, any index: exp <= (m_addr_i == DecoderUnits-1) ? 0 : m_addr_i+1.
  - Dropped push: exp still advances as above, so one drop does not cascade errors.
- row_done_o: registered; asserted for the single cycle after the edge that pops an entry with m_addr_o == DecoderUnits-1.
- flush_i:
  - Same-cycle priority over push/pop.
  - Clears pointers, count and exp; the concurrent input is discarded.
  - Sticky flags are untouched; row_done_o is not asserted.
- clear_err_i: clears overflow_o and seq_err_o. If a new error event occurs in the same cycle, the flag stays set (set wins).
- Simultaneous push and pop on an empty FIFO: the pop is not valid (valid_o=0); the push is taken, count becomes 1.

Test Plan:
- Basic burst:
  - Stimulus: Depth=8, DecoderUnits=4, ready_i=1. Push m_addr 0..3 with results 0x3F800000, 0x40000000, 0x40400000, 0x40800000 on consecutive cycles.
  - Required: same order and values on the outputs, each one cycle after its push. row_done_o pulses once, after the m_addr 3 pop. seq_err_o=0.
- Fill and overflow:
  - Stimulus: ready_i=0, push 9 results.
  - Required: full_o=1 after the 8th push, count_o=8. The 9th is dropped and overflow_o=1. Drain yields exactly the first 8 in order.
- Full with concurrent pop:
  - Stimulus: FIFO full, ready_i=1 and valid_i=1 in the same cycle.
  - Required: push accepted, overflow_o stays 0, count_o stays 8, new entry appears last on drain.
- Sequence error:
  - Stimulus: contiguous pushes with m_addr 0,1,3.
  - Required: seq_err_o=1 from the cycle after the m_addr 3 push.
  - Then: clear_err_i for one cycle -> seq_err_o=0. Idle one cycle, push 0,1,2,3 -> seq_err_o remains 0.
- Flush priority:
  - Stimulus: 5 entries held, assert flush_i together with valid_i and ready_i.
  - Required: count_o=0, empty_o=1, valid_o=0 next cycle. No row_done_o. overflow_o/seq_err_o unchanged.
- Mid-burst reset:
  - Stimulus: rst_i during a 3-entry occupancy, then push m_addr 1.
  - Required: all outputs at reset values. After the push, seq_err_o=1 and count_o=1.
